// File: rtl/chip_bridge_rcv_32.sv
// Chip-side receiver for the credit-based 32-bit virtual-channel link: pairs
// words into 64-bit flits per channel, buffers them, and returns one credit per freed word.
module chip_bridge_rcv_32 #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_from_fpga,
  input  logic [1:0]  channel_from_fpga,
  output logic [2:0]  credit_to_fpga,
  output logic [63:0] bout_data_1,
  output logic [63:0] bout_data_2,
  output logic [63:0] bout_data_3,
  output logic        bout_val_1,
  output logic        bout_val_2,
  output logic        bout_val_3,
  input  logic        bout_rdy_1,
  input  logic        bout_rdy_2,
  input  logic        bout_rdy_3,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(2 * FIFO_DEPTH + 1);
  localparam logic [AW+1:0] CAP_WORDS = (AW + 2)'(2 * FIFO_DEPTH);

  logic [2:0]       rdy_s;
  logic [2:0]       val_s;
  logic [2:0]       drop_s;
  logic [2:0]       credit_s;
  logic [2:0][63:0] head_s;
  logic             overflow_q;

  assign rdy_s = {bout_rdy_3, bout_rdy_2, bout_rdy_1};

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [31:0]   half_q;
    logic          half_vld_q;
    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic [PW-1:0] pend_q;
    logic [PW-1:0] pend_d;
    logic          credit_q;
    logic [AW:0]   count_s;
    logic [AW:0]   count_after_s;
    logic [AW+1:0] words_s;
    logic          val_ch_s;
    logic          arrive_s;
    logic          deq_s;
    logic          full_s;
    logic          cap_s;
    logic          enq_s;

    assign count_s  = wptr_q - rptr_q;
    assign val_ch_s = (count_s != '0);
    assign deq_s    = val_ch_s & rdy_s[c];
    assign arrive_s = (channel_from_fpga == 2'(c + 1));

    // Occupancy is judged after this cycle's dequeue so a full channel can accept a word while draining.
    assign count_after_s = count_s - (AW + 1)'(deq_s);
    assign words_s       = {count_after_s, 1'b0} + (AW + 2)'(half_vld_q);
    assign full_s        = (words_s == CAP_WORDS);
    assign cap_s         = arrive_s & ~full_s & ~half_vld_q;
    assign enq_s         = arrive_s & ~full_s & half_vld_q;
    assign pend_d        = pend_q + (deq_s ? PW'(2) : PW'(0)) - PW'(pend_q != '0);

    assign val_s[c]    = val_ch_s;
    assign drop_s[c]   = arrive_s & full_s;
    assign head_s[c]   = mem_q[rptr_q[AW-1:0]];
    assign credit_s[c] = credit_q;

    // Per-channel half word, flit storage, pointers and credit state.
    always_ff @(posedge clk) begin
      if (rst) begin
        half_q     <= 32'h0;
        half_vld_q <= 1'b0;
        wptr_q     <= '0;
        rptr_q     <= '0;
        pend_q     <= '0;
        credit_q   <= 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          mem_q[i] <= 64'h0;
        end
      end else begin
        if (cap_s) begin
          half_q     <= data_from_fpga;
          half_vld_q <= 1'b1;
        end else if (enq_s) begin
          mem_q[wptr_q[AW-1:0]] <= {half_q, data_from_fpga};
          wptr_q                <= wptr_q + (AW + 1)'(1);
          half_vld_q            <= 1'b0;
        end
        if (deq_s) begin
          rptr_q <= rptr_q + (AW + 1)'(1);
        end
        pend_q   <= pend_d;
        credit_q <= (pend_q != '0);
      end
    end
  end

  // Sticky flag for any word dropped on a full channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q | (|drop_s);
    end
  end

  assign credit_to_fpga = credit_s;
  assign bout_data_1    = head_s[0];
  assign bout_data_2    = head_s[1];
  assign bout_data_3    = head_s[2];
  assign bout_val_1     = val_s[0];
  assign bout_val_2     = val_s[1];
  assign bout_val_3     = val_s[2];
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_chip_bridge_rcv_32.sv
// Bench for chip_bridge_rcv_32: queue-based channel model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_chip_bridge_rcv_32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = 32'h0;
  logic [1:0]  chan = 2'd0;
  logic [2:0]  rdy = 3'b000;
  logic [2:0]  cred;
  logic [63:0] d1, d2, d3;
  logic        v1, v2, v3;
  logic        ovf;

  chip_bridge_rcv_32 #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .data_from_fpga(data), .channel_from_fpga(chan),
    .credit_to_fpga(cred),
    .bout_data_1(d1), .bout_data_2(d2), .bout_data_3(d3),
    .bout_val_1(v1), .bout_val_2(v2), .bout_val_3(v3),
    .bout_rdy_1(rdy[0]), .bout_rdy_2(rdy[1]), .bout_rdy_3(rdy[2]),
    .overflow(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: per-channel flit queue, half word, owed credits.
  logic [63:0] mq [3][$];
  logic [31:0] mhalf [3];
  logic        mhvld [3];
  int          mowed [3];
  logic [2:0]  mcred = 3'b000;
  logic        movf = 1'b0;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        mq[c].delete();
        mhvld[c] <= 1'b0;
        mhalf[c] <= 32'h0;
        mowed[c] <= 0;
      end
      mcred  <= 3'b000;
      movf   <= 1'b0;
      chk_en <= 1'b1;
    end else begin
      for (int c = 0; c < 3; c++) begin
        mcred[c] <= (mowed[c] != 0);
        if ((mq[c].size() != 0) && rdy[c]) begin
          mowed[c] <= mowed[c] + 2 - ((mowed[c] != 0) ? 1 : 0);
          void'(mq[c].pop_front());
        end else begin
          mowed[c] <= mowed[c] - ((mowed[c] != 0) ? 1 : 0);
        end
        if (int'(chan) == c + 1) begin
          if (2 * mq[c].size() + (mhvld[c] ? 1 : 0) >= 2 * DEPTH) begin
            movf <= 1'b1;
          end else if (!mhvld[c]) begin
            mhalf[c] <= data;
            mhvld[c] <= 1'b1;
          end else begin
            mq[c].push_back({mhalf[c], data});
            mhvld[c] <= 1'b0;
          end
        end
      end
    end
  end

  logic [2:0]  dval;
  logic [63:0] ddata [3];
  assign dval = {v3, v2, v1};
  assign ddata[0] = d1;
  assign ddata[1] = d2;
  assign ddata[2] = d3;

  int pulses [3] = '{0, 0, 0};
  int hs [3] = '{0, 0, 0};

  // Per-cycle compare against the model, plus credit/handshake tallies.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("val%0d", c + 1), 64'(dval[c]), 64'(mq[c].size() != 0));
        if (mq[c].size() != 0) begin
          chk($sformatf("data%0d", c + 1), ddata[c], mq[c][0]);
        end
        chk($sformatf("credit%0d", c + 1), 64'(cred[c]), 64'(mcred[c]));
        pulses[c] <= pulses[c] + (cred[c] ? 1 : 0);
        hs[c]     <= hs[c] + ((dval[c] && rdy[c]) ? 1 : 0);
      end
      chk("overflow", 64'(ovf), 64'(movf));
    end
  end

  task automatic step(input logic [1:0] ch, input logic [31:0] d);
    chan = ch;
    data = d;
    @(posedge clk);
    #1;
    chan = 2'd0;
    data = 32'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'd0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] sword(input int k);
    return (k % 2 == 0) ? 32'h1000_0000 + 32'(k / 2) : 32'h2000_0000 + 32'(k / 2);
  endfunction

  int p, h, sent, iter;

  initial begin
    #1;
    idle(2);
    rst = 1'b0;
    // Reset state
    chk("rst_val", 64'(dval), 64'h0);
    chk("rst_cred", 64'(cred), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    chk("rst_data1", d1, 64'h0);
    chk("rst_data3", d3, 64'h0);

    // Single flit on NoC1
    rdy = 3'b001;
    p = pulses[0];
    step(2'd1, 32'hAAAA_0001);
    chk("single_val_early", 64'(v1), 64'h0);
    step(2'd1, 32'hBBBB_0002);
    chk("single_val", 64'(v1), 64'h1);
    chk("single_data", d1, 64'hAAAA0001BBBB0002);
    idle(6);
    chk("single_pulses", 64'(pulses[0] - p), 64'd2);
    chk("single_ovf", 64'(ovf), 64'h0);

    // Interleaving on NoC2/NoC3
    rdy = 3'b000;
    step(2'd2, 32'h2222_000A);
    step(2'd3, 32'h3333_000B);
    step(2'd2, 32'h2222_000C);
    step(2'd3, 32'h3333_000D);
    chk("ilv_data2", d2, 64'h2222000A2222000C);
    chk("ilv_data3", d3, 64'h3333000B3333000D);
    rdy = 3'b111;
    idle(6);

    // Backpressure fill and overflow on NoC3
    do_reset();
    rdy = 3'b000;
    p = pulses[2];
    for (int i = 0; i < 8; i++) step(2'd3, 32'h3000_0000 + 32'(i));
    chk("fill_val3", 64'(v3), 64'h1);
    chk("fill_pulses", 64'(pulses[2] - p), 64'd0);
    chk("fill_ovf", 64'(ovf), 64'h0);
    step(2'd3, 32'h3000_00FF);
    chk("ovf_set", 64'(ovf), 64'h1);
    chk("ovf_head", d3, 64'h3000000030000001);
    h = hs[2];
    rdy = 3'b100;
    idle(12);
    chk("drain_flits", 64'(hs[2] - h), 64'd4);
    chk("drain_pulses", 64'(pulses[2] - p), 64'd8);
    chk("ovf_sticky", 64'(ovf), 64'h1);

    // Full channel with simultaneous word and dequeue
    do_reset();
    rdy = 3'b000;
    for (int i = 0; i < 8; i++) step(2'd3, 32'h4000_0000 + 32'(i));
    rdy = 3'b100;
    step(2'd3, 32'h4000_0008);
    chk("full_deq_ovf", 64'(ovf), 64'h0);
    step(2'd3, 32'h4000_0009);
    chk("full_enq_ovf", 64'(ovf), 64'h0);
    chk("full_head", d3, 64'h4000000440000005);
    idle(8);

    // Streaming 100 flits with random backpressure and sender credit tracking
    do_reset();
    p = pulses[0];
    h = hs[0];
    sent = 0;
    iter = 0;
    while (sent < 200 && iter < 5000) begin
      rdy[0] = 1'($urandom_range(0, 1));
      if (sent - (pulses[0] - p) < 2 * DEPTH) begin
        step(2'd1, sword(sent));
        sent++;
      end else begin
        idle(1);
      end
      iter++;
    end
    chk("stream_sent", 64'(sent), 64'd200);
    rdy[0] = 1'b1;
    iter = 0;
    while (((hs[0] - h) < 100 || (pulses[0] - p) < 200) && iter < 600) begin
      idle(1);
      iter++;
    end
    idle(4);
    chk("stream_flits", 64'(hs[0] - h), 64'd100);
    chk("stream_pulses", 64'(pulses[0] - p), 64'd200);
    chk("stream_cred_idle", 64'(cred[0]), 64'h0);
    chk("stream_ovf", 64'(ovf), 64'h0);

    // Reset mid-flight
    do_reset();
    rdy = 3'b000;
    for (int i = 0; i < 4; i++) step(2'd1, 32'h5000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) step(2'd2, 32'h6000_0000 + 32'(i));
    rdy = 3'b010;
    idle(2);
    rdy = 3'b000;
    chk("mid_cred2", 64'(cred[1]), 64'h1);
    chk("mid_val1", 64'(v1), 64'h1);
    do_reset();
    chk("mid_rst_val", 64'(dval), 64'h0);
    chk("mid_rst_cred", 64'(cred), 64'h0);
    rdy = 3'b001;
    step(2'd1, 32'hC0DE_0001);
    step(2'd1, 32'hC0DE_0002);
    chk("fresh_val", 64'(v1), 64'h1);
    chk("fresh_data", d1, 64'hC0DE0001C0DE0002);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
